// File: rtl/gate_response_checker.sv
// gate_response_checker: on-chip stimulus/response end for the two-input
// basic-gate block. Drives (a,b) = 00,01,10,11, waits SETTLE_CYCLES, samples
// the six gate outputs {and,or,nand,nor,xor,xnor} and compares them against
// the truth table. Reports pass/fail, a saturating error count and the first
// failing vector with its differing bits.
//
// Optional build macro CHECKER_CONTINUOUS_EN: once started, the checker runs
// back-to-back passes forever, accumulating errors across passes, with pass
// sticky-low until reset. Undefined (default): one pass per start request.
`timescale 1ns/1ps

module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       gate_in,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [5:0]       first_fail_bits
);

  // A settle time of zero still needs one cycle for the gate block to respond.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_settle;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [1:0]       r_ff_vec;
  logic [5:0]       r_ff_bits;

  logic [5:0]       w_expected;
  logic [5:0]       w_diff;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;
  logic             w_launch;

  // Truth table of the gate block, ordered {and,or,nand,nor,xor,xnor}.
  function automatic logic [5:0] expected_of(input logic [1:0] v);
    return {v[1] & v[0], v[1] | v[0], ~(v[1] & v[0]),
            ~(v[1] | v[0]), v[1] ^ v[0], ~(v[1] ^ v[0])};
  endfunction

  // Compare the sampled gate outputs against the truth table; saturating count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_err_next = r_err;
    w_expected = expected_of(r_vec);
    w_diff     = gate_in ^ w_expected;
    w_mismatch = |w_diff;
    if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + 1'b1;
    end
  end

`ifdef CHECKER_CONTINUOUS_EN
  // Continuous mode: only the very first request from IDLE starts the checker.
  assign w_launch = start && (r_state == S_IDLE);
`else
  // Single-run mode: a request starts a fresh pass from IDLE or DONE.
  assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));
`endif

  // Sequencer FSM with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vec     <= 2'd0;
      r_settle  <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ff_vec  <= 2'd0;
      r_ff_bits <= 6'd0;
    end else if (w_launch) begin
      r_state   <= S_DRIVE;
      r_vec     <= 2'd0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ff_vec  <= 2'd0;
      r_ff_bits <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_DRIVE: begin
          r_a      <= r_vec[1];
          r_b      <= r_vec[0];
          r_settle <= SETTLE_LOAD;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          // A zero count means no earlier failure has been recorded.
          if (w_mismatch && (r_err == '0)) begin
            r_ff_vec  <= r_vec;
            r_ff_bits <= w_diff;
          end
`ifdef CHECKER_CONTINUOUS_EN
          if (w_mismatch) begin
            r_pass <= 1'b0;
          end
`endif
          if (r_vec == 2'd3) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
`ifdef CHECKER_CONTINUOUS_EN
          r_state <= S_DRIVE;
          r_vec   <= 2'd0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
`else
          r_state <= S_DONE;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o             = r_a;
  assign b_o             = r_b;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_vec  = r_ff_vec;
  assign first_fail_bits = r_ff_bits;

endmodule
